// File: rtl/data_ram_responder.sv
// Purpose : RAM responder with a posted write buffer, read forwarding and a single-port array.
// Latency : reads return one cycle after the request edge; writes reach the array when the port is free.
// Backpr. : none toward the core; ram_busy flags a full buffer, dropped writes set sticky overflow.
//
// Ports:
//   clk, rst               clock (rising edge) and asynchronous active-high reset
//   ram_rd_en, addr_rd     read request / address, data_rd holds the registered result
//   ram_wr_en, addr_wr,    write request / address / data, posted into the write buffer
//   data_wr
//   ram_busy               buffer full
//   wbuf_count             buffer occupancy
//   overflow               sticky, a write was dropped since reset
module data_ram_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 8,
    parameter int WBUF_DEPTH = 2,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_rd_en,
    input  logic [BUS_WIDTH-1:0]  addr_rd,
    output logic [DATA_WIDTH-1:0] data_rd,
    input  logic                  ram_wr_en,
    input  logic [BUS_WIDTH-1:0]  addr_wr,
    input  logic [DATA_WIDTH-1:0] data_wr,
    output logic                  ram_busy,
    output logic [CNT_WIDTH-1:0]  wbuf_count,
    output logic                  overflow
);

    localparam int PTR_W     = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int MEM_DEPTH = 1 << BUS_WIDTH;

    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(WBUF_DEPTH);
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(WBUF_DEPTH - 1);

    typedef struct packed {
        logic [BUS_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    // Storage array: single port, never reset.
    logic [DATA_WIDTH-1:0] mem_array [MEM_DEPTH];

    wbuf_entry_t           wbuf_q [WBUF_DEPTH];
    wbuf_entry_t           wbuf_d [WBUF_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    occ_state_t            occ_q, occ_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;

    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Physical slot of the entry that is 'age' places behind the head.
    function automatic logic [PTR_W-1:0] age_slot(input logic [PTR_W-1:0] head, input int age);
        int s;
        s = int'(head) + age;
        if (s >= WBUF_DEPTH) begin
            s = s - WBUF_DEPTH;
        end
        return PTR_W'(s);
    endfunction

    // Forwarding lookup: scan oldest to newest so the newest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if ((i < int'(count_q)) && (wbuf_q[age_slot(head_q, i)].addr == addr_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = wbuf_q[age_slot(head_q, i)].data;
            end
        end
    end

    always_comb begin
        // A read miss needs the array port, so the drain waits for it.
        pop  = (count_q != '0) && (!ram_rd_en || fwd_hit);
        // Room is judged after this edge's drain, so a full buffer still accepts with a pop.
        push = ram_wr_en && ((count_q != DEPTH_C) || pop);

        head_d = pop  ? ptr_inc(head_q) : head_q;
        tail_d = push ? ptr_inc(tail_q) : tail_q;

        wbuf_d = wbuf_q;
        if (push) begin
            wbuf_d[tail_q] = '{addr: addr_wr, data: data_wr};
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        occ_d = occ_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push && !pop) begin
                    occ_d = (WBUF_DEPTH == 1) ? OCC_FULL : OCC_PARTIAL;
                end
            end
            OCC_PARTIAL: begin
                if (push && !pop && (count_q == DEPTH_C - 1'b1)) begin
                    occ_d = OCC_FULL;
                end else if (pop && !push && (count_q == CNT_WIDTH'(1))) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop && !push) begin
                    occ_d = (WBUF_DEPTH == 1) ? OCC_EMPTY : OCC_PARTIAL;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase

        busy_d = (occ_d == OCC_FULL);
        ovf_d  = ovf_q | (ram_wr_en & ~push);

        // Lookup sees pre-edge state: a same-edge write is not forwarded.
        data_rd_d = data_rd_q;
        if (ram_rd_en) begin
            data_rd_d = fwd_hit ? fwd_data : mem_array[addr_rd];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                wbuf_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            occ_q     <= OCC_EMPTY;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            data_rd_q <= '0;
        end else begin
            wbuf_q    <= wbuf_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            occ_q     <= occ_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            data_rd_q <= data_rd_d;
        end
    end

    // Drain port. Gated by pop, which is never asserted while rst is high
    // after the first edge, so pending entries are discarded on reset.
    always_ff @(posedge clk) begin
        if (pop && !rst) begin
            mem_array[wbuf_q[head_q].addr] <= wbuf_q[head_q].data;
        end
    end

    assign data_rd    = data_rd_q;
    assign ram_busy   = busy_q;
    assign wbuf_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ram_rd_en;
    logic [7:0] addr_rd;
    logic [7:0] data_rd;
    logic       ram_wr_en;
    logic [7:0] addr_wr;
    logic [7:0] data_wr;
    logic       ram_busy;
    logic [1:0] wbuf_count;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    data_ram_responder #(
        .DATA_WIDTH(8),
        .BUS_WIDTH (8),
        .WBUF_DEPTH(DEPTH),
        .CNT_WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ram_rd_en (ram_rd_en),
        .addr_rd   (addr_rd),
        .data_rd   (data_rd),
        .ram_wr_en (ram_wr_en),
        .addr_wr   (addr_wr),
        .data_wr   (data_wr),
        .ram_busy  (ram_busy),
        .wbuf_count(wbuf_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: a queue of posted writes plus an array
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    ent_t       m_q[$];
    logic [7:0] m_mem [256];
    logic [7:0] m_rd;
    bit         m_ovf;

    task automatic model_edge(input bit rd, input logic [7:0] ra, input bit wr,
                              input logic [7:0] wa, input logic [7:0] wd);
        bit         hit;
        logic [7:0] hv;
        hit = 1'b0;
        hv  = 8'h00;
        foreach (m_q[i]) begin
            if (m_q[i].a == ra) begin
                hit = 1'b1;
                hv  = m_q[i].d;
            end
        end
        if (rd) m_rd = hit ? hv : m_mem[ra];
        if (m_q.size() > 0 && (!rd || hit)) begin
            m_mem[m_q[0].a] = m_q[0].d;
            void'(m_q.pop_front());
        end
        if (wr) begin
            if (m_q.size() < DEPTH) m_q.push_back('{wa, wd});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_rd  = 8'h00;
    endtask

    // Value written into every address during preload.
    function automatic logic [7:0] pre(input int a);
        return (a == 8'h30) ? 8'h00 : 8'(a * 3 + 7);
    endfunction

    // ---------------- checking helpers
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic [7:0] e_rd, input logic [1:0] e_cnt,
                              input bit e_busy, input bit e_ovf);
        check({nm, "_data_rd"},  32'(data_rd),    32'(e_rd));
        check({nm, "_count"},    32'(wbuf_count), 32'(e_cnt));
        check({nm, "_busy"},     32'(ram_busy),   32'(e_busy));
        check({nm, "_overflow"}, 32'(overflow),   32'(e_ovf));
    endtask

    task automatic step(input bit rd, input logic [7:0] ra, input bit wr,
                        input logic [7:0] wa, input logic [7:0] wd);
        ram_rd_en = rd;
        addr_rd   = ra;
        ram_wr_en = wr;
        addr_wr   = wa;
        data_wr   = wd;
        @(posedge clk);
        model_edge(rd, ra, wr, wa, wd);
        #1;
        ram_rd_en = 1'b0;
        ram_wr_en = 1'b0;
    endtask

    task automatic pulse_reset(input string nm);
        rst = 1'b1;
        #2;
        model_reset();
        check_outs(nm, 8'h00, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed vector table
    typedef struct {
        bit         rd;
        logic [7:0] ra;
        bit         wr;
        logic [7:0] wa;
        logic [7:0] wd;
        logic [7:0] e_rd;
        logic [1:0] e_cnt;
        bit         e_busy;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rd, input logic [7:0] ra, input bit wr, input logic [7:0] wa,
                       input logic [7:0] wd, input logic [7:0] e_rd, input logic [1:0] e_cnt,
                       input bit e_busy, input bit e_ovf);
        tbl.push_back('{rd, ra, wr, wa, wd, e_rd, e_cnt, e_busy, e_ovf});
    endtask

    initial begin
        logic [7:0] p40;
        rst       = 1'b1;
        ram_rd_en = 1'b0;
        ram_wr_en = 1'b0;
        addr_rd   = 8'h00;
        addr_wr   = 8'h00;
        data_wr   = 8'h00;
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Give every array word a known value, then let the buffer drain.
        for (int a = 0; a < 256; a++) step(1'b0, 8'h00, 1'b1, 8'(a), pre(a));
        repeat (2) step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        pulse_reset("reset_idle");

        p40 = pre(8'h40);
        //   rd  ra     wr  wa     wd     e_rd       cnt busy ovf
        add(0, 8'h00, 1, 8'h10, 8'hA5, 8'h00,      2'd1, 0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 8'h00,      2'd0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 8'h00,      2'd0, 0, 0);
        add(1, 8'h10, 0, 8'h00, 8'h00, 8'hA5,      2'd0, 0, 0);
        add(0, 8'h00, 1, 8'h20, 8'h11, 8'hA5,      2'd1, 0, 0);
        add(1, 8'h20, 0, 8'h00, 8'h00, 8'h11,      2'd0, 0, 0);
        add(1, 8'h30, 1, 8'h30, 8'h77, 8'h00,      2'd1, 0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 8'h00,      2'd0, 0, 0);
        add(1, 8'h30, 0, 8'h00, 8'h00, 8'h77,      2'd0, 0, 0);
        add(1, 8'h40, 1, 8'h50, 8'hC1, p40,        2'd1, 0, 0);
        add(1, 8'h40, 1, 8'h51, 8'hC2, p40,        2'd2, 1, 0);
        add(1, 8'h40, 1, 8'h52, 8'hC3, p40,        2'd2, 1, 1);
        add(0, 8'h00, 0, 8'h00, 8'h00, p40,        2'd1, 0, 1);
        add(0, 8'h00, 0, 8'h00, 8'h00, p40,        2'd0, 0, 1);
        add(1, 8'h52, 0, 8'h00, 8'h00, pre(8'h52), 2'd0, 0, 1);
        add(1, 8'h50, 0, 8'h00, 8'h00, 8'hC1,      2'd0, 0, 1);
        add(1, 8'h40, 1, 8'h70, 8'hD1, p40,        2'd1, 0, 1);
        add(1, 8'h40, 1, 8'h71, 8'hD2, p40,        2'd2, 1, 1);
        add(0, 8'h00, 1, 8'h72, 8'hD3, p40,        2'd2, 1, 1);
        add(1, 8'h72, 0, 8'h00, 8'h00, 8'hD3,      2'd1, 0, 1);
        add(1, 8'h40, 1, 8'h72, 8'hE1, p40,        2'd2, 1, 1);
        add(1, 8'h72, 0, 8'h00, 8'h00, 8'hE1,      2'd1, 0, 1);
        add(0, 8'h00, 0, 8'h00, 8'h00, 8'hE1,      2'd0, 0, 1);
        add(1, 8'h72, 0, 8'h00, 8'h00, 8'hE1,      2'd0, 0, 1);
        add(1, 8'h70, 0, 8'h00, 8'h00, 8'hD1,      2'd0, 0, 1);
        add(1, 8'h71, 0, 8'h00, 8'h00, 8'hD2,      2'd0, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rd, tbl[i].ra, tbl[i].wr, tbl[i].wa, tbl[i].wd);
            check_outs($sformatf("row%0d", i), tbl[i].e_rd, tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_ovf);
        end

        // Reset with two writes still buffered: they must never reach the array.
        pulse_reset("reset_pre");
        step(1'b1, 8'h40, 1'b1, 8'h60, 8'h01);
        check_outs("rbuf1", p40, 2'd1, 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b1, 8'h61, 8'h02);
        check_outs("rbuf2", p40, 2'd2, 1'b1, 1'b0);
        pulse_reset("reset_mid");
        step(1'b1, 8'h60, 1'b0, 8'h00, 8'h00);
        check_outs("after_rst60", pre(8'h60), 2'd0, 1'b0, 1'b0);
        step(1'b1, 8'h61, 1'b0, 8'h00, 8'h00);
        check_outs("after_rst61", pre(8'h61), 2'd0, 1'b0, 1'b0);

        // Randomized traffic on a narrow address window so hits and duplicates are common.
        for (int c = 0; c < 600; c++) begin
            bit         rd;
            bit         wr;
            logic [7:0] ra;
            logic [7:0] wa;
            logic [7:0] wd;
            if (c == 300) pulse_reset("reset_rand");
            rd = ($urandom_range(0, 99) < 45);
            wr = ($urandom_range(0, 99) < 40);
            ra = 8'h80 + 8'($urandom_range(0, 5));
            wa = 8'h80 + 8'($urandom_range(0, 5));
            wd = 8'($urandom);
            step(rd, ra, wr, wa, wd);
            check_outs($sformatf("rand%0d", c), m_rd, 2'(m_q.size()),
                       (m_q.size() == DEPTH), m_ovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
